bcd_convert_scheduler: RTL
==========================

Name: bcd_convert_scheduler

Overview:
- Shares one sequential binary-to-BCD converter (14-bit in, 16-bit 4-digit BCD out, start/done handshake) between NUM_REQ display requesters, e.g. hundredths, seconds, minutes and lap.
- Requesters are served round-robin; each gets a one-cycle response strobe with the BCD result.
- Sits between the stopwatch counters and the 7-segment digit mux.
- Clamps values above 9999 and raises an error on converter timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 32, max cycles in WAIT before aborting (must exceed converter latency).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request; held with req_bin until its req_ready pulse
- req_bin  in  NUM_REQ*14  packed binary values; requester i uses bits [14*i+13:14*i]
- req_ready  out  NUM_REQ  one-hot, one-cycle pulse: request accepted
- resp_valid  out  NUM_REQ  one-hot, one-cycle pulse: result for that requester
- resp_bcd  out  16  result, valid while any resp_valid bit is high; held otherwise
- resp_ovf  out  1  qualifies resp_valid: input was above 9999 and was clamped
- resp_err  out  1  qualifies resp_valid: converter timeout; resp_bcd = 16'h0000
- conv_start  out  1  one-cycle start strobe to converter
- conv_bin  out  14  converter operand; stable from conv_start until done or timeout
- conv_done  in  1  one-cycle completion strobe from converter
- conv_bcd  in  16  converter result, valid with conv_done

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, rr_ptr 0, all outputs 0, timeout counter 0.
- Reset asserted mid-operation aborts it: no response is issued, and later conv_done strobes are ignored while not in WAIT.
- IDLE:
  - Each cycle, scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit g is granted.
  - On grant: latch g and operand = (req_bin[g] > 9999) ? 9999 : req_bin[g]; latch ovf flag; go to START.
  - If no request is pending, stay in IDLE.
- START (one cycle): req_ready[g]=1, conv_start=1, conv_bin=operand; clear timeout counter; go to WAIT.
- WAIT:
  - conv_done=1: latch conv_bcd; go to RESP.
  - Otherwise, when counter reaches TIMEOUT-1: set err; go to RESP.
  - Otherwise increment counter.
  - If conv_done and the timeout occur in the same cycle, conv_done wins.
- RESP (one cycle): resp_valid[g]=1, resp_bcd, resp_ovf, resp_err driven; rr_ptr = (g+1) mod NUM_REQ; go to IDLE.
- Latency:
  - Arbitration cycle T; req_ready and conv_start at T+1.
  - conv_done at T+1+L (L ≥ 1) gives resp_valid at T+2+L.
  - Minimum request-to-request spacing is therefore L+3 cycles.
- conv_done outside WAIT is ignored.
- req_valid dropped before grant is not an error; the request is simply not served.
- A requester re-asserting immediately after its response waits behind all others: rr_ptr has moved past it.
- conv_bin holds its last operand when idle.
- Conversion is only started from the clamped operand, so the operand never exceeds 9999.

Optional Feature:
- Macro: BCD_SCHED_CACHE_EN.
- With the macro defined:
  - Each requester has a cache entry (valid bit, 14-bit clamped operand, 16-bit BCD).
  - On grant in IDLE, if the entry is valid and equals the clamped operand:
    - skip START/WAIT;
    - go to a HIT state asserting req_ready[g] for one cycle, then RESP with the cached BCD (resp_ovf recomputed, resp_err=0);
    - conv_start is not asserted.
  - Entries are written only on a non-timeout completion.
  - All entries are invalidated on reset.
- Without the macro: no cache storage and no HIT state; every grant converts.

Test Plan:
- Reset, then req_valid=4'b0001 with bin=1234; converter model L=15 → req_ready[0] at T+1; conv_start with conv_bin=1234; resp_valid[0] at T+17 with resp_bcd=16'h1234, ovf=0, err=0.
- All four valid simultaneously, bins 5/59/599/9999 → grants in order 0,1,2,3; responses 16'h0005, 16'h0059, 16'h0599, 16'h9999; each req_ready is one-hot.
- Requester 2 with bin=16383 → conv_bin=9999, resp_bcd=16'h9999, resp_ovf=1.
- Converter never asserts conv_done, TIMEOUT=32 → resp_valid pulses 33 cycles after conv_start with resp_err=1 and resp_bcd=0; the next request is served normally.
- Reset asserted during WAIT, then a stale conv_done → no resp_valid; state IDLE; next grant goes to requester 0.
- With BCD_SCHED_CACHE_EN: requester 1 sends 42 twice → the second request gets resp_bcd=16'h0042 two cycles after grant with no conv_start; changing the value to 43 triggers a conversion.

Source files
------------

// File: rtl/bcd_convert_scheduler.sv
// Round-robin scheduler sharing one sequential binary-to-BCD converter among NUM_REQ requesters.
// Optional per-requester result cache: define BCD_SCHED_CACHE_EN.
module bcd_convert_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*14-1:0] req_bin,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [15:0]           resp_bcd,
  output logic                  resp_ovf,
  output logic                  resp_err,
  output logic                  conv_start,
  output logic [13:0]           conv_bin,
  input  logic                  conv_done,
  input  logic [15:0]           conv_bcd
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

`ifdef BCD_SCHED_CACHE_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, WAIT = 3'd2, RESP = 3'd3, HIT = 3'd4} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, WAIT = 3'd2, RESP = 3'd3} state_t;
`endif

  function automatic logic [13:0] sat_bin(input logic [13:0] v);
    return (v > 14'd9999) ? 14'd9999 : v;
  endfunction

  function automatic logic is_ovf(input logic [13:0] v);
    return v > 14'd9999;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] g);
    return NUM_REQ'(1) << g;
  endfunction

  state_t             state, state_n;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_n, gnt, gnt_n, arb_idx;
  logic               found;
  logic [13:0]        operand, operand_n, arb_raw, arb_op;
  logic               ovf, ovf_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [NUM_REQ-1:0] req_ready_n, resp_valid_n;
  logic [15:0]        resp_bcd_n;
  logic               resp_ovf_n, resp_err_n, conv_start_n;
  logic [13:0]        conv_bin_n;

  // Arbitration: first pending requester at or after rr_ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
        found   = 1'b1;
        arb_idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  assign arb_raw = req_bin[int'(arb_idx)*14 +: 14];
  assign arb_op  = sat_bin(arb_raw);

`ifdef BCD_SCHED_CACHE_EN
  logic [NUM_REQ-1:0] cache_vld;
  logic [13:0]        cache_op  [NUM_REQ];
  logic [15:0]        cache_bcd [NUM_REQ];
  logic               cache_we, cache_hit;

  assign cache_hit = cache_vld[arb_idx] && (cache_op[arb_idx] == arb_op);

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld <= '0;
    end else if (cache_we) begin
      cache_vld[gnt] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cache_we) begin
      cache_op[gnt]  <= operand;
      cache_bcd[gnt] <= conv_bcd;
    end
  end
`endif

  // Outputs are computed one cycle ahead so they are registered alongside the state they belong to.
  always_comb begin
    state_n      = state;
    rr_ptr_n     = rr_ptr;
    gnt_n        = gnt;
    operand_n    = operand;
    ovf_n        = ovf;
    cnt_n        = cnt;
    req_ready_n  = '0;
    resp_valid_n = '0;
    conv_start_n = 1'b0;
    conv_bin_n   = conv_bin;
    resp_bcd_n   = resp_bcd;
    resp_ovf_n   = resp_ovf;
    resp_err_n   = resp_err;
`ifdef BCD_SCHED_CACHE_EN
    cache_we     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          gnt_n       = arb_idx;
          operand_n   = arb_op;
          ovf_n       = is_ovf(arb_raw);
          req_ready_n = onehot(arb_idx);
`ifdef BCD_SCHED_CACHE_EN
          if (cache_hit) begin
            state_n = HIT;
          end else begin
            state_n      = START;
            conv_start_n = 1'b1;
            conv_bin_n   = arb_op;
          end
`else
          state_n      = START;
          conv_start_n = 1'b1;
          conv_bin_n   = arb_op;
`endif
        end
      end
      START: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (conv_done) begin
          resp_valid_n = onehot(gnt);
          resp_bcd_n   = conv_bcd;
          resp_ovf_n   = ovf;
          resp_err_n   = 1'b0;
          state_n      = RESP;
`ifdef BCD_SCHED_CACHE_EN
          cache_we     = 1'b1;
`endif
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          resp_valid_n = onehot(gnt);
          resp_bcd_n   = 16'h0000;
          resp_ovf_n   = ovf;
          resp_err_n   = 1'b1;
          state_n      = RESP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP: begin
        rr_ptr_n = PTR_W'((int'(gnt) + 1) % NUM_REQ);
        state_n  = IDLE;
      end
`ifdef BCD_SCHED_CACHE_EN
      HIT: begin
        resp_valid_n = onehot(gnt);
        resp_bcd_n   = cache_bcd[gnt];
        resp_ovf_n   = ovf;
        resp_err_n   = 1'b0;
        state_n      = RESP;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt        <= '0;
      ovf        <= 1'b0;
      cnt        <= '0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_bcd   <= '0;
      resp_ovf   <= 1'b0;
      resp_err   <= 1'b0;
      conv_start <= 1'b0;
      conv_bin   <= '0;
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_ptr_n;
      gnt        <= gnt_n;
      ovf        <= ovf_n;
      cnt        <= cnt_n;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
      resp_bcd   <= resp_bcd_n;
      resp_ovf   <= resp_ovf_n;
      resp_err   <= resp_err_n;
      conv_start <= conv_start_n;
      conv_bin   <= conv_bin_n;
    end
  end

  always_ff @(posedge clk) begin
    operand <= operand_n;
  end

endmodule
